instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
Program loader that fills the 16 x 26-bit instruction memory from a byte stream before the CPU runs. It accepts bytes over a valid/ready handshake and assembles four bytes, MSB first, into one 26-bit instruction word. It then drives the memory write port (prog_pointer, write_data, data_to_write) to store words at consecutive addresses starting at 0. It is the writer end of the instruction-memory write interface.

Parameters:
WORD_W, 26, instruction width (data_to_write width)
ADDR_W, 4, memory address width; depth = 2**ADDR_W = 16
BYTES_PER_WORD, 4, bytes per instruction word (ceil(WORD_W/8))

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
start  in  1  begin a load; accepted only in IDLE
word_count  in  ADDR_W+1  number of words to load; sampled when start is accepted
byte_in  in  8  stream data byte
byte_valid  in  1  byte_in holds a valid byte
byte_ready  out  1  loader accepts a byte this cycle
prog_pointer  out  ADDR_W  memory address
write_data  out  1  memory write strobe; memory writes data_to_write at prog_pointer on rising clk while 1
data_to_write  out  WORD_W  assembled instruction word
busy  out  1  load in progress (any state except IDLE)
done  out  1  one-cycle pulse at load completion
error  out  1  sticky format/overflow flag; cleared on next accepted start or reset

Behaviour:
- Reset (reset=0 at a rising edge): state IDLE. All outputs 0: prog_pointer, data_to_write, write_data, byte_ready, busy, done, error. Partial word and byte counter are cleared. Words already written to memory are not undone.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE, start=1:
  - prog_pointer <= 0, words_left <= word_count, error <= 0.
  - word_count == 0: go to DONE.
  - word_count > 16: clamp words_left to 16, set error, go to COLLECT.
  - Otherwise go to COLLECT.
  - start is ignored in every other state.
- COLLECT:
  - byte_ready = 1. A byte transfers when byte_valid && byte_ready.
  - Shift register: word <= {word[WORD_W-9:0], byte_in}. The first byte lands in bits [25:24] (its bits [1:0]).
  - If the first byte of a word has any nonzero bit in [7:2], set error; the word is still loaded.
  - Gaps (byte_valid=0) stall with no state change.
  - On the 4th accepted byte: data_to_write <= assembled word, go to WRITE.
- WRITE (exactly 1 cycle):
  - write_data = 1, byte_ready = 0, prog_pointer stable.
  - Next cycle: decrement words_left.
  - If words_left reaches 0, go to DONE.
  - Otherwise prog_pointer <= prog_pointer + 1 and go to COLLECT.
  - prog_pointer never wraps; at most 16 writes occur per load.
- DONE: done = 1 for one cycle, then IDLE.
- prog_pointer holds its last value in IDLE until the next start.
- data_to_write holds its value outside WRITE.
- Timing:
  - Write strobe asserts the cycle after the 4th byte handshake.
  - Back-to-back bytes give 5 cycles per word.
  - N-word load at full rate: 1 (start) + 5N + 1 (done) cycles.
- byte_valid in IDLE/WRITE/DONE: not accepted (byte_ready=0); the source must hold the byte.
- Reset during COLLECT or WRITE: the partial word is discarded; a write in the reset cycle is suppressed (write_data forced 0).

Decomposition:
- Shared package:
  - WORD_W, ADDR_W, DEPTH, BYTES_PER_WORD constants.
  - State enum (IDLE, COLLECT, WRITE, DONE).
  - Header-check mask 8'hFC.
  - The instruction memory uses the same constants.
- Sub-module byte_assembler: 26-bit shift register, 2-bit byte counter, word_complete pulse, header-error detect.
- The loader FSM, pointer and words_left counter live in instr_loader.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 and byte_valid=1.
  - Expect all outputs 0 and no write_data pulse.
- Two-word load: start with word_count=2; bytes 03,55,55,55,02,AA,AA,AA back-to-back.
  - Expect write 26'h3555555 at address 0, then 26'h2AAAAAA at address 1.
  - Expect done pulsed once at cycle 12 after start; error=0.
- Gapped stream: same load with byte_valid low 3 cycles between every byte.
  - Expect identical writes, exactly 2 write_data pulses, none during gaps.
- Zero count: word_count=0.
  - Expect done 2 cycles after start, no write_data, error=0.
- Overflow: word_count=20 with 80 bytes offered.
  - Expect 16 writes at addresses 0..15, no wrap, error=1.
  - Expect byte_ready=0 after the 64th byte.
- Bad header and mid-load reset:
  - First byte FF → error=1, data_to_write[25:24]=2'b11.
  - Separately, reset after 2 bytes → no write, IDLE.
  - A fresh 1-word load then writes address 0 correctly.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared constants and types for the instruction-memory program loader.
// The instruction memory uses the same width and depth definitions.
package instr_loader_pkg;

    localparam int WORD_W         = 26;
    localparam int ADDR_W         = 4;
    localparam int DEPTH          = 2 ** ADDR_W;
    localparam int BYTES_PER_WORD = (WORD_W + 7) / 8;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    // First byte of a word may only carry the two top instruction bits.
    localparam logic [7:0]        HDR_MASK  = 8'hFC;
    localparam logic [ADDR_W:0]   MAX_WORDS = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
        return (n > MAX_WORDS) ? MAX_WORDS : n;
    endfunction

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Packs an MSB-first byte stream into instruction words and flags a bad
// header byte (nonzero bits above the instruction width) on the first byte.
module instr_loader_byte_assembler
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_complete,
    output logic              header_err
);

    // Only the low bits survive the next shift, so the top byte is never stored.
    logic [WORD_W-9:0] word_reg;
    logic [CNT_W-1:0]  cnt_reg;

    assign word_next     = {word_reg, byte_in};
    assign word_complete = shift_en && (cnt_reg == CNT_W'(BYTES_PER_WORD - 1));
    assign header_err    = shift_en && (cnt_reg == '0) && (|(byte_in & HDR_MASK));

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_reg <= '0;
            cnt_reg  <= '0;
        end else if (shift_en) begin
            word_reg <= word_next[WORD_W-9:0];
            cnt_reg  <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads instruction words from a byte stream into instruction memory at
// consecutive addresses from 0; writer side of the memory write port.
module instr_loader
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] prog_pointer,
    output logic              write_data,
    output logic [WORD_W-1:0] data_to_write,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W:0]   left_reg, left_next;
    logic [WORD_W-1:0] data_reg, data_next;
    logic              error_reg, error_next;

    logic              byte_fire;
    logic [WORD_W-1:0] asm_word;
    logic              word_complete;
    logic              header_err;

    assign byte_fire = (state_reg == COLLECT) && byte_valid;

    instr_loader_byte_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .shift_en      (byte_fire),
        .byte_in       (byte_in),
        .word_next     (asm_word),
        .word_complete (word_complete),
        .header_err    (header_err)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            left_reg  <= '0;
            data_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            left_reg  <= left_next;
            data_reg  <= data_next;
            error_reg <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        left_next  = left_reg;
        data_next  = data_reg;
        error_next = error_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    ptr_next   = '0;
                    left_next  = clamp_count(word_count);
                    error_next = (word_count > MAX_WORDS);
                    state_next = (word_count == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (header_err) begin
                    error_next = 1'b1;
                end
                if (word_complete) begin
                    data_next  = asm_word;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                left_next = left_reg - (ADDR_W + 1)'(1);
                // Pointer stops at the last written address, so it can never wrap.
                if (left_reg == (ADDR_W + 1)'(1)) begin
                    state_next = DONE;
                end else begin
                    ptr_next   = ptr_reg + ADDR_W'(1);
                    state_next = COLLECT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gating with reset keeps a write from landing in the reset cycle.
    assign byte_ready    = reset && (state_reg == COLLECT);
    assign write_data    = reset && (state_reg == WRITE);
    assign busy          = reset && (state_reg != IDLE);
    assign done          = reset && (state_reg == DONE);
    assign prog_pointer  = ptr_reg;
    assign data_to_write = data_reg;
    assign error         = error_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued with the
// stimulus and matched against writes observed on the memory port.
module tb_instr_loader;

    localparam int WORD_W = 26;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] prog_pointer;
    logic              write_data;
    logic [WORD_W-1:0] data_to_write;
    logic              busy;
    logic              done;
    logic              error;

    instr_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .word_count    (word_count),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .prog_pointer  (prog_pointer),
        .write_data    (write_data),
        .data_to_write (data_to_write),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        obs_q[$];
    logic [7:0] stim_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt;
    int done_lat;
    int accepted;

    // Drives one load (start, then stim_q with `gap` idle cycles between bytes)
    // for `budget` cycles, recording writes, done pulses and accepted bytes.
    task automatic run_load(input logic [ADDR_W:0] wc, input int gap, input int budget);
        int   idx     = 0;
        int   gapc    = 0;
        logic pending = 1'b0;
        obs_q.delete();
        done_cnt = 0;
        done_lat = -1;
        accepted = 0;
        start      = 1'b1;
        word_count = wc;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= budget; t++) begin
            if (write_data) begin
                obs_q.push_back({prog_pointer, data_to_write});
                $display("write addr=%0d data=%h (cycle %0d after start)", prog_pointer, data_to_write, t);
            end
            if (done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = t;
            end
            if (pending) begin
                accepted++;
                idx++;
                byte_valid = 1'b0;
                gapc = gap;
            end
            if (!byte_valid) begin
                if (gapc > 0) begin
                    gapc--;
                end else if (idx < stim_q.size()) begin
                    byte_valid = 1'b1;
                    byte_in    = stim_q[idx];
                end
            end
            pending = byte_valid && byte_ready;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        start      = 1'b1;
        word_count = 5'd2;
        byte_valid = 1'b1;
        byte_in    = 8'h03;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({byte_ready, prog_pointer, write_data, data_to_write, busy, done, error} !== '0)
                $display("FAIL reset_outputs cycle %0d: got rdy=%b ptr=%0d wr=%b data=%h busy=%b done=%b err=%b, need all 0",
                         i, byte_ready, prog_pointer, write_data, data_to_write, busy, done, error);
            else pass_cnt++;
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        reset      = 1'b1;
        $display("reset released");
    endtask

    task automatic test_two_word(input int gap);
        wr_t e, o;
        stim_q = '{8'h03, 8'h55, 8'h55, 8'h55, 8'h02, 8'hAA, 8'hAA, 8'hAA};
        exp_q.push_back({4'd0, 26'h3555555});
        exp_q.push_back({4'd1, 26'h2AAAAAA});
        run_load(5'd2, gap, (gap == 0) ? 16 : 50);
        total_cnt++;
        if (obs_q.size() != 2)
            $display("FAIL two_word_count gap=%0d: got %0d writes, need 2", gap, obs_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e)
                $display("FAIL two_word_write gap=%0d: got addr=%0d data=%h, need addr=%0d data=%h",
                         gap, o.addr, o.data, e.addr, e.data);
            else pass_cnt++;
        end
        exp_q.delete();
        total_cnt++;
        if (done_cnt != 1)
            $display("FAIL two_word_done_count gap=%0d: got %0d, need 1", gap, done_cnt);
        else pass_cnt++;
        if (gap == 0) begin
            total_cnt++;
            if (done_lat != 11)
                $display("FAIL two_word_done_latency: got %0d edges after start, need 11", done_lat);
            else pass_cnt++;
        end
        total_cnt++;
        if (error !== 1'b0)
            $display("FAIL two_word_error gap=%0d: got %b, need 0", gap, error);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        wr_t        e, o;
        logic [7:0] b0, b1, b2, b3;
        stim_q.delete();
        for (int k = 0; k < 20; k++) begin
            b0 = 8'(k & 3);
            b1 = 8'(k);
            b2 = ~8'(k);
            b3 = 8'(k * 3);
            stim_q.push_back(b0);
            stim_q.push_back(b1);
            stim_q.push_back(b2);
            stim_q.push_back(b3);
            if (k < 16) exp_q.push_back({4'(k), b0[1:0], b1, b2, b3});
        end
        run_load(5'd20, 0, 90);
        total_cnt++;
        if (obs_q.size() != 16)
            $display("FAIL overflow_count: got %0d writes, need 16", obs_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e)
                $display("FAIL overflow_write: got addr=%0d data=%h, need addr=%0d data=%h",
                         o.addr, o.data, e.addr, e.data);
            else pass_cnt++;
        end
        exp_q.delete();
        total_cnt++;
        if (accepted != 64)
            $display("FAIL overflow_accepted: got %0d bytes, need 64", accepted);
        else pass_cnt++;
        total_cnt++;
        if ({byte_ready, busy, error} !== 3'b001)
            $display("FAIL overflow_end: got rdy=%b busy=%b err=%b, need rdy=0 busy=0 err=1",
                     byte_ready, busy, error);
        else pass_cnt++;
        total_cnt++;
        if (done_lat != 81)
            $display("FAIL overflow_done_latency: got %0d, need 81", done_lat);
        else pass_cnt++;
        byte_valid = 1'b0;
    endtask

    task automatic test_zero_count();
        stim_q.delete();
        run_load(5'd0, 0, 6);
        total_cnt++;
        if (obs_q.size() != 0)
            $display("FAIL zero_count_writes: got %0d, need 0", obs_q.size());
        else pass_cnt++;
        total_cnt++;
        if (done_lat != 1 || done_cnt != 1)
            $display("FAIL zero_count_done: got latency %0d count %0d, need latency 1 count 1", done_lat, done_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({error, prog_pointer, busy} !== '0)
            $display("FAIL zero_count_state: got err=%b ptr=%0d busy=%b, need all 0", error, prog_pointer, busy);
        else pass_cnt++;
    endtask

    task automatic test_bad_header();
        wr_t e, o;
        stim_q = '{8'hFF, 8'h00, 8'h00, 8'h00};
        exp_q.push_back({4'd0, 26'h3000000});
        run_load(5'd1, 0, 10);
        total_cnt++;
        if (obs_q.size() != 1)
            $display("FAIL bad_header_count: got %0d writes, need 1", obs_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e)
                $display("FAIL bad_header_write: got addr=%0d data=%h, need addr=%0d data=%h",
                         o.addr, o.data, e.addr, e.data);
            else pass_cnt++;
        end
        exp_q.delete();
        total_cnt++;
        if (error !== 1'b1 || data_to_write[25:24] !== 2'b11)
            $display("FAIL bad_header_flag: got err=%b top=%b, need err=1 top=11", error, data_to_write[25:24]);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        wr_t e, o;
        start      = 1'b1;
        word_count = 5'd1;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h01;
        @(negedge clk);
        byte_in = 8'h23;
        @(negedge clk);
        byte_valid = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({write_data, busy, byte_ready, error} !== 4'b0000)
            $display("FAIL mid_reset_state: got wr=%b busy=%b rdy=%b err=%b, need all 0",
                     write_data, busy, byte_ready, error);
        else pass_cnt++;
        reset = 1'b1;
        $display("mid-load reset applied");
        stim_q = '{8'h01, 8'h23, 8'h45, 8'h67};
        exp_q.push_back({4'd0, 26'h1234567});
        run_load(5'd1, 0, 10);
        total_cnt++;
        if (obs_q.size() != 1)
            $display("FAIL fresh_load_count: got %0d writes, need 1", obs_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e)
                $display("FAIL fresh_load_write: got addr=%0d data=%h, need addr=%0d data=%h",
                         o.addr, o.data, e.addr, e.data);
            else pass_cnt++;
        end
        exp_q.delete();
        total_cnt++;
        if (error !== 1'b0)
            $display("FAIL fresh_load_error: got %b, need 0", error);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_two_word(0);
        test_two_word(3);
        test_overflow();
        test_zero_count();
        test_bad_header();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
